// File: rtl/xc_rf_wb_seq.sv
// Writeback sequencer for the 3R/1W GPR file: buffers execute results, splits
// 64-bit results into even/odd pair writes, and flags RAW hazards to issue.
module xc_rf_wb_seq #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic        wb_wide,
  input  logic [31:0] wb_wdata_lo,
  input  logic [31:0] wb_wdata_hi,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rs3_addr,
  output logic        rs1_pending,
  output logic        rs2_pending,
  output logic        rs3_pending,
  output logic        idle
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wide;
    logic [31:0] lo;
    logic [31:0] hi;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_e;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [3:0]       cur_pair_q, cur_pair_d;
  logic             cur_wide_q, cur_wide_d;
  logic [31:0]      cur_hi_q, cur_hi_d;
  logic             rd_wen_q, rd_wen_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [31:0]      rd_wdata_q, rd_wdata_d;
  logic             push, pop;
  entry_t           head, in_entry, scan;
  logic [4:0]       rs_addr [3];
  logic [2:0]       pend;

  assign wb_ready = (count_q < CNT_W'(DEPTH));
  assign push     = wb_valid && wb_ready;
  assign head     = mem_q[rd_ptr_q];
  assign in_entry = '{rd: wb_rd, wide: wb_wide, lo: wb_wdata_lo, hi: wb_wdata_hi};

  // Port sequencing: finish a wide pair before popping the next entry.
  always_comb begin
    state_d    = state_q;
    cur_pair_d = cur_pair_q;
    cur_wide_d = cur_wide_q;
    cur_hi_d   = cur_hi_q;
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    pop        = 1'b0;
    if (state_q == ST_LO && cur_wide_q) begin
      state_d    = ST_HI;
      rd_addr_d  = {cur_pair_q, 1'b1};
      rd_wdata_d = cur_hi_q;
    end else if (count_q != '0) begin
      pop        = 1'b1;
      state_d    = ST_LO;
      cur_pair_d = head.rd[4:1];
      cur_wide_d = head.wide;
      cur_hi_d   = head.hi;
      rd_addr_d  = head.wide ? {head.rd[4:1], 1'b0} : head.rd;
      rd_wdata_d = head.lo;
    end else begin
      state_d = ST_IDLE;
    end
    rd_wen_d = (state_d != ST_IDLE) && (rd_addr_d != 5'd0);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_pair_q <= '0;
      cur_wide_q <= 1'b0;
      cur_hi_q   <= '0;
      rd_wen_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_pair_q <= cur_pair_d;
      cur_wide_q <= cur_wide_d;
      cur_hi_q   <= cur_hi_d;
      rd_wen_q   <= rd_wen_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;
  assign rs_addr[2] = rs3_addr;

  // Hazard scan: current port entry plus every valid queued entry.
  always_comb begin
    pend = '0;
    scan = '0;
    for (int k = 0; k < 3; k++) begin
      if (state_q != ST_IDLE &&
          (rs_addr[k] == rd_addr_q ||
           (state_q == ST_LO && cur_wide_q && rs_addr[k][4:1] == cur_pair_q)))
        pend[k] = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        scan = mem_q[rd_ptr_q + PTR_W'(i)];
        if (CNT_W'(i) < count_q &&
            (scan.wide ? (scan.rd[4:1] == rs_addr[k][4:1]) : (scan.rd == rs_addr[k])))
          pend[k] = 1'b1;
      end
      if (rs_addr[k] == 5'd0) pend[k] = 1'b0;
    end
  end

  assign rs1_pending = pend[0];
  assign rs2_pending = pend[1];
  assign rs3_pending = pend[2];
  assign rd_wen      = rd_wen_q;
  assign rd_addr     = rd_addr_q;
  assign rd_wdata    = rd_wdata_q;
  assign idle        = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_xc_rf_wb_seq.sv
// Randomized bench for xc_rf_wb_seq against a queue-of-writes reference model.
module tb_xc_rf_wb_seq;

  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ready, wb_wide;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata_lo, wb_wdata_hi;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic        rs1_pending, rs2_pending, rs3_pending, idle;

  xc_rf_wb_seq #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_wide(wb_wide),
    .wb_wdata_lo(wb_wdata_lo), .wb_wdata_hi(wb_wdata_hi),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending), .rs3_pending(rs3_pending),
    .idle(idle)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] rd; logic wide; logic [31:0] lo; logic [31:0] hi; } ent_t;
  typedef struct { logic [4:0] a; logic [31:0] d; } op_t;

  ent_t mfifo [$];
  op_t  cur_q [$];
  ent_t dir_q [$];
  bit   m_hi;
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // A register is pending if any write still to be performed targets it.
  function automatic bit m_pend(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (cur_q[i]) if (cur_q[i].a == rs) return 1'b1;
    foreach (mfifo[i]) begin
      if (mfifo[i].wide) begin
        if ((rs >> 1) == (mfifo[i].rd >> 1)) return 1'b1;
      end else if (mfifo[i].rd == rs) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic compare_all();
    bit busy;
    busy = (cur_q.size() != 0);
    check_eq("rd_wen", 32'(rd_wen), 32'(busy && cur_q[0].a != 5'd0));
    if (busy) begin
      check_eq("rd_addr", 32'(rd_addr), 32'(cur_q[0].a));
      check_eq("rd_wdata", rd_wdata, cur_q[0].d);
    end
    check_eq("wb_ready", 32'(wb_ready), 32'(mfifo.size() < DEPTH));
    check_eq("idle", 32'(idle), 32'(mfifo.size() == 0 && !busy));
    check_eq("rs1_pending", 32'(rs1_pending), 32'(m_pend(rs1_addr)));
    check_eq("rs2_pending", 32'(rs2_pending), 32'(m_pend(rs2_addr)));
    check_eq("rs3_pending", 32'(rs3_pending), 32'(m_pend(rs3_addr)));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_wen"}, 32'(rd_wen), 32'd0);
    check_eq({tag, "_addr"}, 32'(rd_addr), 32'd0);
    check_eq({tag, "_wdata"}, rd_wdata, 32'd0);
    check_eq({tag, "_ready"}, 32'(wb_ready), 32'd1);
    check_eq({tag, "_idle"}, 32'(idle), 32'd1);
    check_eq({tag, "_pend"}, 32'({rs1_pending, rs2_pending, rs3_pending}), 32'd0);
  endtask

  // One clock edge of the reference: finish the pair, else take next result.
  task automatic model_step(input bit acc);
    ent_t e;
    op_t  o;
    if (cur_q.size() > 1) begin
      void'(cur_q.pop_front());
      m_hi = 1'b1;
    end else begin
      m_hi = 1'b0;
      cur_q.delete();
      if (mfifo.size() != 0) begin
        e = mfifo.pop_front();
        if (e.wide) begin
          o.a = {e.rd[4:1], 1'b0}; o.d = e.lo; cur_q.push_back(o);
          o.a = {e.rd[4:1], 1'b1}; o.d = e.hi; cur_q.push_back(o);
        end else begin
          o.a = e.rd; o.d = e.lo; cur_q.push_back(o);
        end
      end
    end
    if (acc) begin
      e.rd = wb_rd; e.wide = wb_wide; e.lo = wb_wdata_lo; e.hi = wb_wdata_hi;
      mfifo.push_back(e);
    end
  endtask

  task automatic add_dir(input logic [4:0] rd, input logic wide, input logic [31:0] lo,
                         input logic [31:0] hi);
    ent_t e;
    e.rd = rd; e.wide = wide; e.lo = lo; e.hi = hi;
    dir_q.push_back(e);
  endtask

  initial begin
    bit   hold, acc;
    int   vprob, n_rst;
    ent_t e;
    hold = 1'b0; n_rst = 0; m_hi = 1'b0;
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_wide = 1'b0;
    wb_wdata_lo = '0; wb_wdata_hi = '0;
    rs1_addr = 5'd3; rs2_addr = 5'd5; rs3_addr = 5'd7;
    #1 check_reset_state("por");
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;

    add_dir(5'd5, 1'b0, 32'hDEADBEEF, 32'h0);
    add_dir(5'd7, 1'b1, 32'h11111111, 32'h22222222);
    add_dir(5'd0, 1'b0, 32'hAAAA0000, 32'h0);
    add_dir(5'd1, 1'b1, 32'hBBBB0000, 32'hCCCC0000);
    add_dir(5'd2, 1'b1, 32'h00000002, 32'h00000003);
    add_dir(5'd4, 1'b1, 32'h00000004, 32'h00000005);
    add_dir(5'd6, 1'b1, 32'h00000006, 32'h00000007);
    add_dir(5'd8, 1'b1, 32'h00000008, 32'h00000009);
    add_dir(5'd9, 1'b0, 32'h99999999, 32'h0);
    add_dir(5'd12, 1'b1, 32'h0C0C0C0C, 32'h0D0D0D0D);
    add_dir(5'd3, 1'b0, 32'h33333333, 32'h0);

    for (int cyc = 0; cyc < 1900; cyc++) begin
      vprob = (cyc < 700) ? 40 : (cyc < 1300) ? 80 : (cyc < 1850) ? 100 : 0;
      if (!hold) begin
        if (dir_q.size() != 0) begin
          e = dir_q.pop_front();
          wb_valid = 1'b1; wb_rd = e.rd; wb_wide = e.wide;
          wb_wdata_lo = e.lo; wb_wdata_hi = e.hi;
        end else begin
          wb_valid    = ($urandom_range(99) < vprob);
          wb_rd       = 5'($urandom_range(15));
          wb_wide     = 1'($urandom_range(1));
          wb_wdata_lo = $urandom;
          wb_wdata_hi = $urandom;
        end
      end
      if (cyc < 40) begin
        rs1_addr = 5'd6; rs2_addr = 5'd9; rs3_addr = 5'd0;
      end else begin
        rs1_addr = 5'($urandom_range(15));
        rs2_addr = 5'($urandom_range(15));
        rs3_addr = 5'($urandom_range(15));
      end
      @(negedge clock);
      compare_all();
      acc = wb_valid && (mfifo.size() < DEPTH);
      if (cyc > 30 && m_hi && mfifo.size() != 0 && n_rst < 4) begin
        #1 reset = 1'b1; wb_valid = 1'b0;
        #1 check_reset_state("midrst");
        @(posedge clock); #1 reset = 1'b0;
        mfifo.delete(); cur_q.delete(); m_hi = 1'b0; hold = 1'b0;
        n_rst++;
        continue;
      end
      @(posedge clock);
      model_step(acc);
      hold = wb_valid && !acc;
      #1;
    end
    check_eq("mid_resets_seen", 32'(n_rst > 0), 32'd1);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
